// File: rtl/se_pkg.sv
// Shared widths, FSM state type and output saturation for the SE squeeze FC stage.
package se_pkg;
    localparam int C_IN   = 16;
    localparam int C_OUT  = 4;
    localparam int DATA_W = 9;
    localparam int W_W    = 8;
    localparam int ACC_W  = 24;
    localparam int SHIFT  = 7;

    localparam int AW = $clog2(C_IN * C_OUT);
    localparam int IW = $clog2(C_IN);
    localparam int CW = $clog2(C_IN + 2);
    localparam int JW = (C_OUT > 1) ? $clog2(C_OUT) : 1;
    localparam int PW = DATA_W + W_W + 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} se_state_t;

    // ReLU + arithmetic shift + clamp to the unsigned result range.
    function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = acc >>> SHIFT;
        if (r[ACC_W-1])
            return '0;
        else if (|r[ACC_W-2:DATA_W])
            return '1;
        else
            return r[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/se_mac.sv
// Registered signed multiply-accumulate: unsigned activation times signed weight.
module se_mac
    import se_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [DATA_W-1:0]        x_i,
    input  logic signed [W_W-1:0]    w_i,
    output logic signed [ACC_W-1:0]  acc_o
);
    logic signed [PW-1:0]    xs, ws, prod;
    logic signed [ACC_W-1:0] acc_q;

    // Zero-extend the activation into a signed operand so the product stays signed.
    assign xs   = PW'($signed({1'b0, x_i}));
    assign ws   = PW'(w_i);
    assign prod = xs * ws;

    always_ff @(posedge clk) begin
        if (reset)
            acc_q <= '0;
        else if (clr_i)
            acc_q <= '0;
        else if (en_i)
            acc_q <= acc_q + ACC_W'(prod);
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/se_squeeze_fc.sv
// SE reduce stage: buffers C_IN pooled values, runs C_OUT dot products against ROM weights,
// and streams ReLU/shift/saturated results over valid/ready.
module se_squeeze_fc
    import se_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [AW-1:0]     w_addr,
    input  logic [W_W-1:0]    w_data,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow_err
);
    se_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [JW-1:0]     j_q, j_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vout_q, vout_d;
    logic              ovf_q;
    logic              en_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] sbuf_q [C_IN];
    logic              clr, buf_we, issue;
    logic signed [ACC_W-1:0] acc;

    // cnt doubles as the load index and the compute cycle counter (C_IN issues + 2 drain).
    assign issue = (state_q == COMPUTE) && (cnt_q < CW'(C_IN));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        dout_d  = dout_q;
        vout_d  = vout_q;
        clr     = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            LOAD: begin
                if (valid_in) begin
                    buf_we = 1'b1;
                    if (cnt_q == CW'(C_IN - 1)) begin
                        cnt_d   = '0;
                        j_d     = '0;
                        clr     = 1'b1;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == CW'(C_IN + 1)) begin
                    cnt_d   = '0;
                    dout_d  = saturate(acc);
                    vout_d  = 1'b1;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (vout_q && out_ready) begin
                    vout_d = 1'b0;
                    cnt_d  = '0;
                    if (j_q == JW'(C_OUT - 1)) begin
                        j_d     = '0;
                        state_d = LOAD;
                    end else begin
                        j_d     = j_q + 1'b1;
                        clr     = 1'b1;
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            j_q     <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            en_q    <= issue;
            if (valid_in && state_q != LOAD)
                ovf_q <= 1'b1;
        end
    end

    // Operand is registered alongside the address so it lines up with the ROM's 1-cycle latency.
    always_ff @(posedge clk) begin
        if (buf_we)
            sbuf_q[cnt_q[IW-1:0]] <= data_in;
        x_q <= sbuf_q[cnt_q[IW-1:0]];
    end

    se_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .en_i  (en_q),
        .x_i   (x_q),
        .w_i   ($signed(w_data)),
        .acc_o (acc)
    );

    assign w_addr       = issue ? (AW'(j_q) * AW'(C_IN) + AW'(cnt_q)) : '0;
    assign data_out     = dout_q;
    assign valid_out    = vout_q;
    assign busy         = (state_q != LOAD);
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_se_squeeze_fc.sv
// Directed bench for se_squeeze_fc with a 1-cycle-latency weight ROM model.
module tb_se_squeeze_fc;
    logic       clk = 0;
    logic       reset = 1;
    logic [8:0] data_in = '0;
    logic       valid_in = 0;
    logic [5:0] w_addr;
    logic [7:0] w_data = '0;
    logic [8:0] data_out;
    logic       valid_out;
    logic       out_ready = 1;
    logic       busy;
    logic       overflow_err;

    logic signed [7:0] rom [64];
    logic [8:0] vin [16];
    logic [8:0] expv [4];
    int tests_run = 0;
    int tests_failed = 0;

    se_squeeze_fc dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .w_addr(w_addr), .w_data(w_data), .data_out(data_out), .valid_out(valid_out),
        .out_ready(out_ready), .busy(busy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) w_data <= rom[w_addr];

    task automatic do_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic send_vec();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1 data_in = vin[i]; valid_in = 1;
        end
        @(posedge clk); #1 valid_in = 0;
    endtask

    // Called at a negedge; counts posedges until valid_out is seen high (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_out && n < 60) begin
            @(posedge clk); @(negedge clk); n++;
        end
    endtask

    // Accepts all four outputs with out_ready high; expects 18 edges from the last
    // input sample / previous accept to valid_out (valid_in cycle + 19).
    task automatic collect(input string nm, input bit lat0);
        int n;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            wait_valid(n);
            if (j > 0 || lat0) begin
                tests_run++;
                if (n !== 18) begin
                    tests_failed++;
                    $display("FAIL %s latency out%0d: got %0d edges, want 18", nm, j, n);
                end
            end
            tests_run++;
            if (data_out !== expv[j]) begin
                tests_failed++;
                $display("FAIL %s data out%0d: got %0d, want %0d", nm, j, data_out, expv[j]);
            end
            @(posedge clk); @(negedge clk);
        end
        tests_run++;
        if ({valid_out, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s idle after last accept: valid_out=%b busy=%b, want 0 0", nm, valid_out, busy);
        end
    endtask

    task automatic set_uniform(input logic [8:0] d, input logic signed [7:0] w);
        for (int i = 0; i < 16; i++) vin[i] = d;
        for (int k = 0; k < 64; k++) rom[k] = w;
    endtask

    // d=i*32; w0=+1, w1=-1/+2 split, w2=+i, w3=-i -> 30, 39, 310, 0
    task automatic set_mixed();
        for (int i = 0; i < 16; i++) begin
            vin[i] = 9'(i * 32);
            rom[i]      = 8'sd1;
            rom[16 + i] = (i < 8) ? -8'sd1 : 8'sd2;
            rom[32 + i] = 8'(i);
            rom[48 + i] = 8'(-i);
        end
        expv[0] = 9'd30; expv[1] = 9'd39; expv[2] = 9'd310; expv[3] = 9'd0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({valid_out, busy, overflow_err, data_out, w_addr} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset state: vo=%b busy=%b ovf=%b dout=%0d addr=%0d, want all 0",
                     valid_out, busy, overflow_err, data_out, w_addr);
        end
    endtask

    task automatic test_basic();
        set_uniform(9'd100, 8'sd1);
        for (int j = 0; j < 4; j++) expv[j] = 9'd12;
        send_vec();
        collect("basic", 1'b1);
    endtask

    task automatic test_order();
        for (int i = 0; i < 16; i++) vin[i] = 9'd100;
        for (int k = 0; k < 64; k++) rom[k] = 8'(k / 16 + 1);
        expv[0] = 9'd12; expv[1] = 9'd25; expv[2] = 9'd37; expv[3] = 9'd50;
        send_vec();
        collect("order", 1'b1);
    endtask

    task automatic test_mixed();
        set_mixed();
        send_vec();
        collect("mixed", 1'b1);
    endtask

    task automatic test_relu();
        set_uniform(9'd511, -8'sd128);
        for (int j = 0; j < 4; j++) expv[j] = 9'd0;
        send_vec();
        collect("relu", 1'b0);
    endtask

    task automatic test_saturate();
        set_uniform(9'd511, 8'sd127);
        for (int j = 0; j < 4; j++) expv[j] = 9'd511;
        send_vec();
        collect("saturate", 1'b0);
    endtask

    task automatic test_stall();
        int n;
        set_mixed();
        out_ready = 0;
        send_vec();
        @(negedge clk);
        wait_valid(n);
        tests_run++;
        if (data_out !== expv[0]) begin
            tests_failed++;
            $display("FAIL stall first data: got %0d, want %0d", data_out, expv[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            tests_run++;
            if ({valid_out, data_out} !== {1'b1, expv[0]}) begin
                tests_failed++;
                $display("FAIL stall hold cycle %0d: vo=%b dout=%0d, want 1 %0d", c, valid_out, data_out, expv[0]);
            end
        end
        out_ready = 1;
        @(posedge clk); @(negedge clk);
        for (int j = 1; j < 4; j++) begin
            wait_valid(n);
            tests_run++;
            if (data_out !== expv[j]) begin
                tests_failed++;
                $display("FAIL stall data out%0d: got %0d, want %0d", j, data_out, expv[j]);
            end
            @(posedge clk); @(negedge clk);
        end
        tests_run++;
        if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall idle: valid_out=%b, want 0", valid_out);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_uniform(9'd100, 8'sd1);
        send_vec();
        repeat (5) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        tests_run++;
        if ({valid_out, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid after reset: vo=%b busy=%b, want 0 0", valid_out, busy);
        end
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid_out) seen = 1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid partial output: valid_out seen=%b, want 0", seen);
        end
        set_mixed();
        send_vec();
        collect("reset_mid", 1'b1);
    endtask

    task automatic test_overflow();
        set_mixed();
        send_vec();
        @(negedge clk);
        tests_run++;
        if (overflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow before drop: got %b, want 0", overflow_err);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 data_in = 9'd511; valid_in = 1;
            @(posedge clk); #1 valid_in = 0;
        end
        @(negedge clk);
        tests_run++;
        if (overflow_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow set: got %b, want 1", overflow_err);
        end
        collect("overflow", 1'b0);
        tests_run++;
        if (overflow_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow sticky: got %b, want 1", overflow_err);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = '0;
        for (int i = 0; i < 16; i++) vin[i] = '0;
        test_reset();
        test_basic();
        test_order();
        test_mixed();
        test_relu();
        test_saturate();
        test_stall();
        test_reset_mid();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
